// File: rtl/mux_arb_nxw.sv
// Registered N-channel word multiplexer with valid/ready handshakes and
// manual, fixed-priority and round-robin channel selection.
module mux_arb_nxw #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [1:0]                MODE,
  input  logic [SEL_W-1:0]          SEL,
  input  logic [CHANNELS*WIDTH-1:0] ENT,
  input  logic [CHANNELS-1:0]       ENT_VALID,
  output logic [CHANNELS-1:0]       ENT_READY,
  output logic [WIDTH-1:0]          OUT,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [SEL_W-1:0]          OUT_CH
);

  typedef enum logic [1:0] {
    MODE_MANUAL     = 2'b00,
    MODE_PRIO       = 2'b01,
    MODE_RR         = 2'b10,
    MODE_MANUAL_ALT = 2'b11
  } mode_e;

  localparam logic [SEL_W:0] CH_L   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W:0] LAST_L = (SEL_W+1)'(CHANNELS - 1);

  mode_e            mode;
  logic [WIDTH-1:0] ent_arr [CHANNELS];

  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic [SEL_W-1:0] idx;
  logic [SEL_W:0]   rr_idx;
  logic             load_en;
  logic             take;

  assign mode = mode_e'(MODE);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign ent_arr[i] = ENT[i*WIDTH +: WIDTH];
  end

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    rr_idx      = '0;
    case (mode)
      MODE_PRIO: begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          idx = SEL_W'(k);
          if (!grant_valid && ENT_VALID[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
          end
        end
      end
      MODE_RR: begin
        // Search upward from the pointer with wrap; first valid channel wins.
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          rr_idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
          if (rr_idx >= CH_L) rr_idx = rr_idx - CH_L;
          idx = rr_idx[SEL_W-1:0];
          if (!grant_valid && ENT_VALID[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
          end
        end
      end
      default: begin
        if (({1'b0, SEL} < CH_L) && ENT_VALID[SEL]) begin
          grant       = SEL;
          grant_valid = 1'b1;
        end
      end
    endcase
  end

  assign load_en = !vld_q || OUT_READY;
  assign take    = load_en && grant_valid;

  always_comb begin
    ENT_READY = '0;
    if (!RESET && take) ENT_READY[grant] = 1'b1;
  end

  always_comb begin
    out_d = out_q;
    ch_d  = ch_q;
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (load_en) begin
      vld_d = grant_valid;
      if (grant_valid) begin
        out_d = ent_arr[grant];
        ch_d  = grant;
        if (mode == MODE_RR)
          ptr_d = ({1'b0, grant} == LAST_L) ? '0 : grant + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_q <= '0;
      ch_q  <= '0;
      vld_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      out_q <= out_d;
      ch_q  <= ch_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = vld_q;
  assign OUT_CH    = ch_q;

endmodule

// File: tb/tb_mux_arb_nxw.sv
// Bench for mux_arb_nxw: behavioural model checked every cycle, plus directed
// literal expectations for each selection mode, backpressure and reset.
module tb_mux_arb_nxw;

  localparam int C = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [1:0]  sel;
  logic [31:0] ent;
  logic [3:0]  ent_valid;
  logic [3:0]  ent_ready;
  logic [7:0]  out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  logic [1:0]  mode2;
  logic [0:0]  sel2;
  logic [15:0] ent2;
  logic [1:0]  ent_valid2;
  logic [1:0]  ent_ready2;
  logic [7:0]  out2;
  logic        out_valid2;
  logic        out_ready2;
  logic [0:0]  out_ch2;

  int errors = 0;
  int checks = 0;

  mux_arb_nxw #(.WIDTH(8), .CHANNELS(4)) dut (
    .CLK(clk), .RESET(rst), .MODE(mode), .SEL(sel), .ENT(ent),
    .ENT_VALID(ent_valid), .ENT_READY(ent_ready), .OUT(out),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_CH(out_ch)
  );

  mux_arb_nxw #(.WIDTH(8), .CHANNELS(2)) dut2 (
    .CLK(clk), .RESET(rst), .MODE(mode2), .SEL(sel2), .ENT(ent2),
    .ENT_VALID(ent_valid2), .ENT_READY(ent_ready2), .OUT(out2),
    .OUT_VALID(out_valid2), .OUT_READY(out_ready2), .OUT_CH(out_ch2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: grant from the selection rules, -1 when nothing is granted.
  function automatic int model_grant(input logic [1:0] md, input int s,
                                     input logic [3:0] v, input int ptr);
    if (md == 2'b01) begin
      for (int i = 0; i < C; i++) if (v[i]) return i;
    end else if (md == 2'b10) begin
      for (int k = 0; k < C; k++) if (v[(ptr + k) % C]) return (ptr + k) % C;
    end else begin
      if (s < C && v[s]) return s;
    end
    return -1;
  endfunction

  int         m_ptr;
  int         m_ch;
  logic [7:0] m_out;
  logic       m_vld;
  int         m_g;
  logic [3:0] exp_ready;

  assign m_g       = model_grant(mode, int'(sel), ent_valid, m_ptr);
  assign exp_ready = (!rst && (!m_vld || out_ready) && m_g >= 0) ? 4'(1 << m_g) : 4'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out <= 8'h00; m_vld <= 1'b0; m_ch <= 0; m_ptr <= 0;
    end else if (!m_vld || out_ready) begin
      if (m_g >= 0) begin
        m_out <= ent[m_g*8 +: 8];
        m_ch  <= m_g;
        m_vld <= 1'b1;
        if (mode == 2'b10) m_ptr <= (m_g + 1) % C;
      end else begin
        m_vld <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_out_valid", 32'(out_valid), 32'(m_vld));
    if (m_vld) begin
      chk("model_out", 32'(out), 32'(m_out));
      chk("model_out_ch", 32'(out_ch), 32'(m_ch));
    end
    chk("model_ent_ready", 32'(ent_ready), 32'(exp_ready));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; sel = 2'd0; ent = '0; ent_valid = '0; out_ready = 1'b0;
    mode2 = 2'b00; sel2 = 1'b0; ent2 = '0; ent_valid2 = '0; out_ready2 = 1'b0;
    repeat (3) tick();
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_ch", 32'(out_ch), 32'h0);
    chk("reset_ready", 32'(ent_ready), 32'h0);
    rst = 1'b0;

    // Manual mode on both instances
    ent = {8'h44, 8'h33, 8'h3C, 8'hC3}; ent_valid = 4'b1111; sel = 2'd1; out_ready = 1'b1;
    ent2 = {8'h3C, 8'hC3}; ent_valid2 = 2'b11; sel2 = 1'b1; out_ready2 = 1'b1;
    #1;
    chk("man_ready", 32'(ent_ready), 32'b0010);
    chk("man2_ready", 32'(ent_ready2), 32'b10);
    tick();
    chk("man_out_sel1", 32'(out), 32'h3C);
    chk("man_ch_sel1", 32'(out_ch), 32'd1);
    chk("man2_out_sel1", 32'(out2), 32'h3C);
    chk("man2_ch_sel1", 32'(out_ch2), 32'd1);
    sel = 2'd0; sel2 = 1'b0;
    tick();
    chk("man_out_sel0", 32'(out), 32'hC3);
    chk("man_ch_sel0", 32'(out_ch), 32'd0);
    chk("man2_out_sel0", 32'(out2), 32'hC3);
    chk("man2_ch_sel0", 32'(out_ch2), 32'd0);
    chk("man2_valid", 32'(out_valid2), 32'd1);
    mode = 2'b11; sel = 2'd3;
    tick();
    chk("mode3_out", 32'(out), 32'h44);
    chk("mode3_ch", 32'(out_ch), 32'd3);
    mode = 2'b00; sel = 2'd2; ent_valid = 4'b1011;
    #1;
    chk("man_nogrant_ready", 32'(ent_ready), 32'h0);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_out_hold", 32'(out), 32'h44);

    // Fixed priority
    mode = 2'b01; ent = {8'h13, 8'h12, 8'h11, 8'h10}; ent_valid = 4'b1010;
    #1;
    chk("prio_ready", 32'(ent_ready), 32'b0010);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("prio_out", 32'(out), 32'h11);
      chk("prio_ch", 32'(out_ch), 32'd1);
      chk("prio_ready_hold", 32'(ent_ready), 32'b0010);
    end

    // Round-robin fairness
    mode = 2'b10; ent_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_out", 32'(out), 32'(8'h10 + (i % 4)));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure
    ent_valid = 4'b0000;
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);
    ent_valid = 4'b1111; out_ready = 1'b0;
    tick();
    chk("bp_first", 32'(out), 32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_out", 32'(out), 32'h10);
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
      chk("bp_stall_ready", 32'(ent_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ent_ready), 32'b0010);
    tick();
    chk("bp_next", 32'(out), 32'h11);

    // Wrap and sparse (pointer brought to 1 first)
    ent_valid = 4'b0001;
    tick();
    chk("wrap_setup", 32'(out), 32'h10);
    ent_valid = 4'b1001;
    tick(); chk("wrap_a", 32'(out), 32'h13); chk("wrap_a_v", 32'(out_valid), 32'd1);
    tick(); chk("wrap_b", 32'(out), 32'h10); chk("wrap_b_v", 32'(out_valid), 32'd1);
    tick(); chk("wrap_c", 32'(out), 32'h13); chk("wrap_c_v", 32'(out_valid), 32'd1);

    // Pointer retained across a mode change
    mode = 2'b01; ent_valid = 4'b1111;
    tick(); chk("mchg_prio", 32'(out), 32'h10);
    mode = 2'b10;
    tick(); chk("mchg_rr0", 32'(out), 32'h10);
    tick(); chk("mchg_rr1", 32'(out), 32'h11);

    // Asynchronous reset mid-stream
    mode = 2'b00; sel = 2'd0; ent = {8'h13, 8'h12, 8'h11, 8'hA5}; ent_valid = 4'b0001;
    tick();
    chk("ar_load", 32'(out), 32'hA5);
    out_ready = 1'b0;
    tick();
    chk("ar_hold", 32'(out), 32'hA5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("ar_out", 32'(out), 32'h0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_ch", 32'(out_ch), 32'd0);
    chk("ar_ready", 32'(ent_ready), 32'h0);
    #1;
    rst = 1'b0; mode = 2'b10; ent = {8'h13, 8'h12, 8'h11, 8'h10};
    ent_valid = 4'b1111; out_ready = 1'b1;
    #1;
    chk("ar_first_ready", 32'(ent_ready), 32'b0001);
    tick();
    chk("ar_first_out", 32'(out), 32'h10);
    chk("ar_first_ch", 32'(out_ch), 32'd0);
    tick();
    chk("ar_second_out", 32'(out), 32'h11);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_nxw.md
Name: mux_arb_nxw

Overview:
- Parametrised, registered N-channel word multiplexer; next generation of the team's 2:1 byte mux.
- Generalises channel count and data width.
- Adds a valid/ready handshake on every input and on the output, plus three selection modes: manual select, fixed priority and round-robin.
- Sits between multiple byte/word producers and a single downstream consumer; one output register stage decouples timing.

Parameters:
- WIDTH, 8, data width of each channel and of OUT.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS), width of select/index signals; derived, not overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- MODE  input  2  00 manual (SEL), 01 fixed priority (channel 0 highest), 10 round-robin, 11 treated as 00.
- SEL  input  SEL_W  channel index used in manual mode.
- ENT  input  CHANNELS*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
- ENT_VALID  input  CHANNELS  per-channel data valid.
- ENT_READY  output  CHANNELS  per-channel accept; at most one bit high.
- OUT  output  WIDTH  registered selected data.
- OUT_VALID  output  1  OUT holds a word.
- OUT_READY  input  1  consumer accepts OUT this cycle.
- OUT_CH  output  SEL_W  index of the channel that produced OUT.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - OUT=0, OUT_VALID=0, OUT_CH=0.
  - Round-robin pointer = 0.
  - ENT_READY=0 while RESET is high.
  - Words in flight are discarded.
- Output register:
  - load_en = !OUT_VALID | OUT_READY.
  - Full throughput: one word per cycle when the consumer keeps OUT_READY=1.
- Grant (combinational):
  - Manual: grant = SEL if ENT_VALID[SEL]=1, else none. SEL >= CHANNELS means no grant.
  - Fixed priority: lowest-index valid channel.
  - Round-robin: first valid channel searching upward from pointer, with wrap-around CHANNELS-1 -> 0.
- ENT_READY[g] = load_en & grant_valid; all other bits 0. ENT_READY must not depend on ENT_VALID of non-granted channels beyond the grant logic.
- Transfer: channel g transfers when ENT_VALID[g] & ENT_READY[g].
  - Next edge: OUT <= ENT[g], OUT_CH <= g, OUT_VALID <= 1.
  - Latency: input handshake to OUT_VALID is 1 cycle.
- Drain: if load_en and no grant, OUT_VALID <= 0; OUT and OUT_CH hold their last value.
- Stall: OUT_VALID=1 & OUT_READY=0 -> OUT, OUT_CH and OUT_VALID hold; all ENT_READY=0.
- Simultaneous accept and load (OUT_READY=1, new grant) -> OUT replaced in the same edge; no bubble.
- Round-robin pointer:
  - Updates only on a transfer in round-robin mode: pointer <= (g==CHANNELS-1) ? 0 : g+1.
  - Unchanged by stalls, idle cycles and the other modes.
- Mode change: MODE/SEL sampled combinationally each cycle.
  - A change takes effect for the next grant.
  - A word already in OUT is unaffected.
  - Pointer retained across mode changes.
- No data loss or duplication: each input handshake produces exactly one OUT handshake, in order.

Test Plan:
- Reset mid-stream: OUT_VALID=1, OUT=8'hA5; assert RESET asynchronously between edges -> OUT=0, OUT_VALID=0, OUT_CH=0 immediately. After release with MODE=10 and all valid, first grant is channel 0.
- Manual mode, CHANNELS=2, WIDTH=8: ENT={8'h3C,8'hC3}, both valid, SEL=1, OUT_READY=1 -> ENT_READY=2'b10, next cycle OUT=8'h3C, OUT_CH=1. Then SEL=0 -> OUT=8'hC3, OUT_CH=0.
- Fixed priority: ENT_VALID=4'b1010, OUT_READY=1 -> channel 1 served every cycle; channel 3 never granted while channel 1 stays valid.
- Round-robin fairness: all 4 channels valid continuously, channel i data = 8'h10+i, OUT_READY=1 -> OUT sequence 10,11,12,13,10,... with OUT_VALID high every cycle after the first.
- Backpressure: round-robin, all valid, OUT_READY held 0 for 3 cycles after first load -> OUT=8'h10 stable, ENT_READY=0 throughout. On OUT_READY=1, the next word is 8'h11 (pointer not advanced during the stall).
- Wrap and sparse: ENT_VALID=4'b1001, pointer at 1 -> grant 3, then 0, then 3, with no idle cycles.
